// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared encodings for the memory port arbiter: FSM state codes and the
//   2:1 address/write-data mux select values.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    // Grant decision when both sides may be requesting. rr selects the
    // round-robin tie-break against last_owner; otherwise data has priority.
    function automatic logic pick_winner(input logic if_req,
                                         input logic d_req,
                                         input logic last_owner,
                                         input logic rr);
        logic w;
        if (rr && if_req && d_req)
            w = ~last_owner;
        else
            w = d_req ? SEL_DATA : SEL_FETCH;
        return w;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
//   Counts cycles while enabled and flags expiry on the cycle the count
//   reaches TIMEOUT_CYC-1. With TIMEOUT_CYC == 0 the counter is not built and
//   expire is tied low.
// Ports
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  zero the count
//   en      in  count this cycle
//   expire  out combinational: en && count == TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst, clr, en};
            assign expire    = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || clr)
                    cnt <= '0;
                else if (en)
                    cnt <= cnt + 1'b1;
            end

            assign expire = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (requester 0)
//   and MEM-stage data access (requester 1). Drives the 2:1 mux select,
//   sequences IDLE -> BUSY -> ACK and pulses the owner's ack. A watchdog
//   forces completion if the port never answers and latches timeout_err.
//   Optional macro ARB_RR_EN: round-robin tie-break instead of data priority.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req, d_req     requests, held until the matching ack
//   d_we              data request is a write (sampled at grant)
//   port_req, port_we memory port request / write strobe
//   port_ready        port finished the access this cycle (BUSY only)
//   sel               mux select: 0 fetch, 1 data
//   if_ack, d_ack     one-cycle completion pulses
//   busy              state is not IDLE
//   timeout_err       sticky watchdog flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic d_we,
    output logic port_req,
    output logic port_we,
    input  logic port_ready,
    output logic sel,
    output logic if_ack,
    output logic d_ack,
    output logic busy,
    output logic timeout_err
);

    arb_state_t state;
    logic       winner;
    logic       expire;
    logic       in_busy;

`ifdef ARB_RR_EN
    logic last_owner;
    assign winner = pick_winner(if_req, d_req, last_owner, 1'b1);

    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= SEL_FETCH;
        else if (state == ST_IDLE && (if_req || d_req))
            last_owner <= winner;
    end
`else
    assign winner = pick_winner(if_req, d_req, SEL_FETCH, 1'b0);
`endif

    assign in_busy = (state == ST_BUSY);

    // Count is held at zero outside BUSY, so every transaction starts fresh.
    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (~in_busy),
        .en     (in_busy),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            port_req    <= 1'b0;
            port_we     <= 1'b0;
            sel         <= SEL_FETCH;
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    // sel keeps its last value while nobody asks
                    if (if_req || d_req) begin
                        state    <= ST_BUSY;
                        sel      <= winner;
                        port_req <= 1'b1;
                        port_we  <= (winner == SEL_DATA) && d_we;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // sel/port_we frozen; ack goes to the owner whether the
                    // port answered or the watchdog gave up
                    if (port_ready || expire) begin
                        state    <= ST_ACK;
                        port_req <= 1'b0;
                        port_we  <= 1'b0;
                        if_ack   <= (sel == SEL_FETCH);
                        d_ack    <= (sel == SEL_DATA);
                        if (!port_ready)
                            timeout_err <= 1'b1;
                    end
                end
                ST_ACK: begin
                    // no arbitration here: the requester is still dropping req
                    state  <= ST_IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    port_req <= 1'b0;
                    port_we  <= 1'b0;
                    if_ack   <= 1'b0;
                    d_ack    <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
